// File: rtl/rv_decode_issue_if.sv
// rv_decode_issue_if: instruction handshake, ALU operand/return bus and
// retire/branch report bundle for rv_decode_issue.
// The master side is the decode/issue unit; the slave side is the instruction
// source plus the registered ALU. retired_count exists only when
// ISSUE_PERF_CNT_EN is defined.
interface rv_decode_issue_if;
  // instruction handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  // ALU drive and registered return
  logic        ex_en;
  logic [3:0]  alu_control;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_out;
  logic        zero;
  // completion report
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        illegal;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] retired_count;
`endif

  modport master (
    input  instr_valid, instr, pc, alu_out, zero,
    output instr_ready, ex_en, alu_control, rs1_data, rs2_data,
           retire_valid, retire_rd, retire_data,
           branch_valid, branch_taken, branch_target, illegal
`ifdef ISSUE_PERF_CNT_EN
           , retired_count
`endif
  );

  modport slave (
    output instr_valid, instr, pc, alu_out, zero,
    input  instr_ready, ex_en, alu_control, rs1_data, rs2_data,
           retire_valid, retire_rd, retire_data,
           branch_valid, branch_taken, branch_target, illegal
`ifdef ISSUE_PERF_CNT_EN
           , retired_count
`endif
  );
endinterface

// File: rtl/rv_decode_issue.sv
// rv_decode_issue: non-pipelined RV32I decode/issue stage in front of a
// registered ALU. Handles OP, OP-IMM, BRANCH, LUI and AUIPC with a fixed
// IDLE -> DECODE -> EXEC -> WB sequence (illegal encodings leave from DECODE).
// Owns a 32x32 register file; x0 is hard-wired to zero.
// Optional feature macro: ISSUE_PERF_CNT_EN adds the retired_count counter.
module rv_decode_issue #(
  parameter int REGFILE_RESET = 1  // 1: clear register file on reset, 0: retain
) (
  input  logic              clk,
  input  logic              reset,  // synchronous, active low
  rv_decode_issue_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;
  localparam logic [3:0] ALU_BLT  = 4'b1100;
  localparam logic [3:0] ALU_BGE  = 4'b1101;
  localparam logic [3:0] ALU_BLTU = 4'b1110;
  localparam logic [3:0] ALU_BGEU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] instr_q, pc_q;
  logic [31:0] rs1_data_q, rs2_data_q, branch_target_q;
  logic [3:0]  alu_control_q;

  // instruction fields, taken from the latched word so they stay valid to WB
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm_i, imm_b, imm_u, shamt_ext;

  logic [31:0] rs1_val, rs2_val;
  logic        dec_illegal, dec_branch;
  logic [3:0]  alu_ctl_d;
  logic [31:0] op_a_d, op_b_d;
  logic        rf_we;

  logic [31:0] rf_rd [32];

  assign opcode    = instr_q[6:0];
  assign rd_idx    = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign rs1_idx   = instr_q[19:15];
  assign rs2_idx   = instr_q[24:20];
  assign funct7    = instr_q[31:25];
  assign imm_i     = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_b     = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                      instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u     = {instr_q[31:12], 12'b0};
  assign shamt_ext = {27'b0, instr_q[24:20]};

  // ---------------------------------------------------------------------------
  // Register file: one word per architectural register, x0 is a constant.
  // Flops rather than RAM because a whole-file clear on reset is required.
  // ---------------------------------------------------------------------------
  assign rf_rd[0] = '0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    logic [31:0] reg_q;
    // per-register clear on reset (optional) and write-back at the WB edge
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (REGFILE_RESET != 0) begin
          reg_q <= '0;
        end
      end else if (rf_we && (rd_idx == 5'(gi))) begin
        reg_q <= bus.alu_out;
      end
    end
    assign rf_rd[gi] = reg_q;
  end

  assign rs1_val = rf_rd[rs1_idx];
  assign rs2_val = rf_rd[rs2_idx];

  // WB write: non-branch instructions only, writes to x0 are discarded
  assign rf_we = (state_q == S_WB) && !dec_branch && (rd_idx != 5'd0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: fixed walk, illegal encodings leave straight from DECODE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = dec_illegal ? S_IDLE : S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs: pulses decoded from the state; WB results qualified by state
  always_comb begin
    bus.instr_ready   = (state_q == S_IDLE) && reset;
    bus.ex_en         = (state_q == S_EXEC);
    bus.illegal       = (state_q == S_DECODE) && dec_illegal;
    bus.retire_valid  = (state_q == S_WB);
    bus.branch_valid  = (state_q == S_WB) && dec_branch;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.retire_rd     = '0;
    bus.retire_data   = '0;
    if (state_q == S_WB) begin
      if (dec_branch) begin
        bus.branch_taken  = bus.zero;
        bus.branch_target = branch_target_q;
      end else begin
        bus.retire_rd   = rd_idx;
        bus.retire_data = bus.alu_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // capture the instruction word and its pc on the handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if ((state_q == S_IDLE) && bus.instr_valid) begin
      instr_q <= bus.instr;
      pc_q    <= bus.pc;
    end
  end

  // decode: operand muxing, ALU opcode and legality of the latched word
  always_comb begin
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    alu_ctl_d   = ALU_ADD;
    op_a_d      = rs1_val;
    op_b_d      = rs2_val;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alu_ctl_d = ALU_ADD;
            3'b001:  alu_ctl_d = ALU_SLL;
            3'b010:  alu_ctl_d = ALU_SLT;
            3'b011:  alu_ctl_d = ALU_SLTU;
            3'b100:  alu_ctl_d = ALU_XOR;
            3'b101:  alu_ctl_d = ALU_SRL;
            3'b110:  alu_ctl_d = ALU_OR;
            default: alu_ctl_d = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  alu_ctl_d = ALU_SUB;
            3'b101:  alu_ctl_d = ALU_SRA;
            default: dec_illegal = 1'b1;
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        op_b_d = imm_i;
        case (funct3)
          3'b000: alu_ctl_d = ALU_ADD;
          3'b010: alu_ctl_d = ALU_SLT;
          3'b011: alu_ctl_d = ALU_SLTU;
          3'b100: alu_ctl_d = ALU_XOR;
          3'b110: alu_ctl_d = ALU_OR;
          3'b111: alu_ctl_d = ALU_AND;
          3'b001: begin
            op_b_d    = shamt_ext;
            alu_ctl_d = ALU_SLL;
            if (funct7 != 7'b0000000) dec_illegal = 1'b1;
          end
          default: begin  // 3'b101: srli / srai
            op_b_d = shamt_ext;
            if (funct7 == 7'b0000000) begin
              alu_ctl_d = ALU_SRL;
            end else if (funct7 == 7'b0100000) begin
              alu_ctl_d = ALU_SRA;
            end else begin
              dec_illegal = 1'b1;
            end
          end
        endcase
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000:  alu_ctl_d = ALU_BEQ;
          3'b001:  alu_ctl_d = ALU_BNE;
          3'b100:  alu_ctl_d = ALU_BLT;
          3'b101:  alu_ctl_d = ALU_BGE;
          3'b110:  alu_ctl_d = ALU_BLTU;
          3'b111:  alu_ctl_d = ALU_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op_a_d = '0;
        op_b_d = imm_u;
      end
      OPC_AUIPC: begin
        op_a_d = pc_q;
        op_b_d = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // register operands, opcode and branch target at the end of DECODE;
  // they then stay put through EXEC while the ALU samples them
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs1_data_q      <= '0;
      rs2_data_q      <= '0;
      alu_control_q   <= '0;
      branch_target_q <= '0;
    end else if ((state_q == S_DECODE) && !dec_illegal) begin
      rs1_data_q      <= op_a_d;
      rs2_data_q      <= op_b_d;
      alu_control_q   <= alu_ctl_d;
      branch_target_q <= pc_q + imm_b;
    end
  end

  assign bus.alu_control = alu_control_q;
  assign bus.rs1_data    = rs1_data_q;
  assign bus.rs2_data    = rs2_data_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] retired_count_q;

  // count completed instructions (illegal drops never reach WB); wraps
  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_count_q <= '0;
    end else if (state_q == S_WB) begin
      retired_count_q <= retired_count_q + 32'd1;
    end
  end

  assign bus.retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_rv_decode_issue.sv
// tb_rv_decode_issue: randomized and directed bench for rv_decode_issue.
// A registered ALU stub answers ex_en; an architectural RV32I model
// (register array + instruction semantics) predicts every completion.
module tb_rv_decode_issue;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rv_decode_issue_if bus();

  rv_decode_issue #(.REGFILE_RESET(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- registered ALU stub ----------------
  logic [31:0] alu_r;
  logic        alu_z;

  function automatic void alu_model(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic z);
    r = a - b;
    z = 1'b0;
    case (c)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = a << b[4:0];
      4'd6:  r = a >> b[4:0];
      4'd7:  r = $signed(a) >>> b[4:0];
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd10: z = (a == b);
      4'd11: z = (a != b);
      4'd12: z = ($signed(a) < $signed(b));
      4'd13: z = ($signed(a) >= $signed(b));
      4'd14: z = (a < b);
      default: z = (a >= b);
    endcase
    if (c < 4'd10) z = (r == 32'd0);
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      bus.alu_out <= '0;
      bus.zero    <= 1'b0;
    end else if (bus.ex_en) begin
      alu_model(bus.alu_control, bus.rs1_data, bus.rs2_data, alu_r, alu_z);
      bus.alu_out <= alu_r;
      bus.zero    <= alu_z;
    end
  end

  // ---------------- architectural reference model ----------------
  logic [31:0] ref_x [32];
  int          ref_retired;
  int          exp_kind;   // 0 = register write, 1 = branch, 2 = illegal
  logic [4:0]  exp_rd;
  logic [31:0] exp_val, exp_tgt;
  logic        exp_tk;

  task automatic model_step(input logic [31:0] ins, input logic [31:0] p);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, immi, immb, immu;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = ref_x[ins[19:15]]; b = ref_x[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    immu = {ins[31:12], 12'b0};
    exp_kind = 0; exp_rd = ins[11:7]; exp_val = '0; exp_tk = 1'b0; exp_tgt = '0;
    if (op == 7'h33) begin
      if (f7 != 7'h00 && f7 != 7'h20) exp_kind = 2;
      else if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) exp_kind = 2;
      else case (f3)
        3'd0: exp_val = f7[5] ? a - b : a + b;
        3'd1: exp_val = a << b[4:0];
        3'd2: exp_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: exp_val = (a < b) ? 32'd1 : 32'd0;
        3'd4: exp_val = a ^ b;
        3'd5: exp_val = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: exp_val = a | b;
        default: exp_val = a & b;
      endcase
    end else if (op == 7'h13) begin
      case (f3)
        3'd0: exp_val = a + immi;
        3'd2: exp_val = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
        3'd3: exp_val = (a < immi) ? 32'd1 : 32'd0;
        3'd4: exp_val = a ^ immi;
        3'd6: exp_val = a | immi;
        3'd7: exp_val = a & immi;
        3'd1: if (f7 != 7'h00) exp_kind = 2; else exp_val = a << ins[24:20];
        default: begin
          if (f7 == 7'h00) exp_val = a >> ins[24:20];
          else if (f7 == 7'h20) exp_val = 32'($signed(a) >>> ins[24:20]);
          else exp_kind = 2;
        end
      endcase
    end else if (op == 7'h63) begin
      if (f3 == 3'd2 || f3 == 3'd3) exp_kind = 2;
      else begin
        exp_kind = 1; exp_rd = 5'd0; exp_tgt = p + immb;
        case (f3)
          3'd0: exp_tk = (a == b);
          3'd1: exp_tk = (a != b);
          3'd4: exp_tk = ($signed(a) < $signed(b));
          3'd5: exp_tk = ($signed(a) >= $signed(b));
          3'd6: exp_tk = (a < b);
          default: exp_tk = (a >= b);
        endcase
      end
    end else if (op == 7'h37) exp_val = immu;
    else if (op == 7'h17) exp_val = p + immu;
    else exp_kind = 2;
    if (exp_kind == 0 && exp_rd != 5'd0) ref_x[exp_rd] = exp_val;
    if (exp_kind != 2) ref_retired++;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // ---------------- driver / observer ----------------
  int          obs_ex_count, obs_ex_cycle, obs_ret_count, obs_ret_cycle;
  int          obs_ill_count, obs_ill_cycle, obs_ready_cycle;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data, obs_tgt;
  logic        obs_bv, obs_tk;

  // Present one instruction, then watch the four cycles after the handshake
  // edge (cycle 1 = DECODE). Also advances the reference model.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] p);
    int waitc;
    waitc = 0;
    obs_ex_count = 0; obs_ex_cycle = 0; obs_ret_count = 0; obs_ret_cycle = 0;
    obs_ill_count = 0; obs_ill_cycle = 0; obs_ready_cycle = 0;
    obs_rd = '0; obs_data = '0; obs_tgt = '0; obs_bv = 1'b0; obs_tk = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = ins; bus.pc = p;
    while (bus.instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      tests_run++; tests_failed++;
      $display("FAIL handshake_timeout instr_ready=%b required=1", bus.instr_ready);
      bus.instr_valid = 1'b0;
      return;
    end
    model_step(ins, p);
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.instr_valid = 1'b0; bus.instr = $urandom; bus.pc = $urandom;
      end
      if (bus.ex_en === 1'b1) begin obs_ex_count++; obs_ex_cycle = c; end
      if (bus.illegal === 1'b1) begin obs_ill_count++; obs_ill_cycle = c; end
      if (bus.instr_ready === 1'b1 && obs_ready_cycle == 0) obs_ready_cycle = c;
      if (bus.retire_valid === 1'b1) begin
        obs_ret_count++; obs_ret_cycle = c;
        obs_rd = bus.retire_rd; obs_data = bus.retire_data;
        obs_bv = bus.branch_valid; obs_tk = bus.branch_taken; obs_tgt = bus.branch_target;
      end
    end
    $display("[TB] instr=%h pc=%h ex=%0d@%0d ret=%0d@%0d rd=%0d data=%h br=%b tk=%b tgt=%h ill=%0d rdy@%0d",
             ins, p, obs_ex_count, obs_ex_cycle, obs_ret_count, obs_ret_cycle, obs_rd,
             obs_data, obs_bv, obs_tk, obs_tgt, obs_ill_count, obs_ready_cycle);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.instr_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low got=%b exp=0", bus.instr_ready); end
    tests_run++;
    if ({bus.ex_en, bus.retire_valid, bus.branch_valid, bus.illegal} !== 4'b0) begin
      tests_failed++; $display("FAIL reset_pulses got=%b exp=0000", {bus.ex_en, bus.retire_valid, bus.branch_valid, bus.illegal});
    end
    tests_run++;
    if ({bus.rs1_data, bus.rs2_data, bus.alu_control} !== 68'b0) begin
      tests_failed++; $display("FAIL reset_operands got=%h exp=0", {bus.rs1_data, bus.rs2_data, bus.alu_control});
    end
`ifdef ISSUE_PERF_CNT_EN
    tests_run++;
    if (bus.retired_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", bus.retired_count); end
`endif
    reset = 1'b1;
    #2;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got=%b exp=1", bus.instr_ready); end
    for (int i = 0; i < 32; i++) ref_x[i] = '0;
    ref_retired = 0;
  endtask

  task automatic test_addi_add();
    run_instr(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 32'h0);
    tests_run++;
    if (obs_data !== 32'd5 || obs_rd !== 5'd1) begin tests_failed++; $display("FAIL addi_result got=%0d/x%0d exp=5/x1", obs_data, obs_rd); end
    tests_run++;
    if (obs_ex_count !== 1 || obs_ex_cycle !== 2) begin tests_failed++; $display("FAIL addi_ex_timing got=%0d@%0d exp=1@2", obs_ex_count, obs_ex_cycle); end
    tests_run++;
    if (obs_ret_cycle !== 3 || obs_ready_cycle !== 4) begin tests_failed++; $display("FAIL addi_ret_timing got=ret@%0d rdy@%0d exp=ret@3 rdy@4", obs_ret_cycle, obs_ready_cycle); end
    run_instr(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 32'h4);
    tests_run++;
    if (obs_data !== 32'd10 || obs_rd !== 5'd2) begin tests_failed++; $display("FAIL add_result got=%0d/x%0d exp=10/x2", obs_data, obs_rd); end
    tests_run++;
    if (obs_ex_count !== 1 || obs_ex_cycle !== 2) begin tests_failed++; $display("FAIL add_ex_timing got=%0d@%0d exp=1@2", obs_ex_count, obs_ex_cycle); end
  endtask

  task automatic test_x0();
    run_instr(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 32'h8);
    tests_run++;
    if (obs_ret_count !== 1 || obs_rd !== 5'd0) begin tests_failed++; $display("FAIL x0_retire got=%0d/x%0d exp=1/x0", obs_ret_count, obs_rd); end
    run_instr(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), 32'hC);
    tests_run++;
    if (obs_data !== 32'd0) begin tests_failed++; $display("FAIL x0_read got=%h exp=0", obs_data); end
  endtask

  task automatic test_branch();
    run_instr(enc_i(12'hFFF, 5'd0, 3'd0, 5'd3), 32'h10);
    run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd4), 32'h14);
    run_instr(enc_b(13'd16, 5'd4, 5'd3, 3'b100), 32'h100);
    tests_run++;
    if (obs_bv !== 1'b1 || obs_tk !== 1'b1 || obs_tgt !== 32'h110) begin
      tests_failed++; $display("FAIL blt got=bv%b tk%b %h exp=bv1 tk1 00000110", obs_bv, obs_tk, obs_tgt);
    end
    tests_run++;
    if (obs_rd !== 5'd0 || obs_data !== 32'd0 || obs_ret_count !== 1) begin
      tests_failed++; $display("FAIL blt_retire got=x%0d %h n%0d exp=x0 0 n1", obs_rd, obs_data, obs_ret_count);
    end
    run_instr(enc_b(13'd16, 5'd4, 5'd3, 3'b110), 32'h100);
    tests_run++;
    if (obs_bv !== 1'b1 || obs_tk !== 1'b0) begin tests_failed++; $display("FAIL bltu got=bv%b tk%b exp=bv1 tk0", obs_bv, obs_tk); end
    run_instr(enc_b(13'h1FF8, 5'd3, 5'd3, 3'b000), 32'h4);
    tests_run++;
    if (obs_tk !== 1'b1 || obs_tgt !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL beq_wrap got=tk%b %h exp=tk1 fffffffc", obs_tk, obs_tgt); end
  endtask

  task automatic test_lui_auipc();
    run_instr(enc_u(20'hFFFFF, 5'd5, 7'h37), 32'h20);
    tests_run++;
    if (obs_data !== 32'hFFFF_F000) begin tests_failed++; $display("FAIL lui got=%h exp=fffff000", obs_data); end
    run_instr(enc_u(20'h00001, 5'd6, 7'h17), 32'hFFFF_F000);
    tests_run++;
    if (obs_data !== 32'h0 || obs_rd !== 5'd6) begin tests_failed++; $display("FAIL auipc_wrap got=%h/x%0d exp=0/x6", obs_data, obs_rd); end
  endtask

  task automatic test_illegal();
    int cnt_before;
    cnt_before = ref_retired;
    run_instr(32'h0000_0000, 32'h30);
    tests_run++;
    if (obs_ill_count !== 1 || obs_ill_cycle !== 1) begin tests_failed++; $display("FAIL illegal_pulse got=%0d@%0d exp=1@1", obs_ill_count, obs_ill_cycle); end
    tests_run++;
    if (obs_ex_count !== 0 || obs_ret_count !== 0) begin tests_failed++; $display("FAIL illegal_no_exec got=ex%0d ret%0d exp=0/0", obs_ex_count, obs_ret_count); end
    tests_run++;
    if (obs_ready_cycle !== 2) begin tests_failed++; $display("FAIL illegal_ready got=%0d exp=2", obs_ready_cycle); end
`ifdef ISSUE_PERF_CNT_EN
    tests_run++;
    if (bus.retired_count !== 32'(cnt_before)) begin tests_failed++; $display("FAIL illegal_count got=%0d exp=%0d", bus.retired_count, cnt_before); end
`endif
    run_instr(enc_r(7'h20, 5'd1, 5'd1, 3'b001, 5'd5), 32'h34);
    tests_run++;
    if (obs_ill_count !== 1) begin tests_failed++; $display("FAIL illegal_op_f3 got=%0d exp=1", obs_ill_count); end
    run_instr(enc_i({7'h20, 5'd3}, 5'd1, 3'b001, 5'd5), 32'h38);
    tests_run++;
    if (obs_ill_count !== 1) begin tests_failed++; $display("FAIL illegal_slli got=%0d exp=1", obs_ill_count); end
    run_instr(enc_b(13'd8, 5'd1, 5'd1, 3'b010), 32'h3C);
    tests_run++;
    if (obs_ill_count !== 1) begin tests_failed++; $display("FAIL illegal_branch got=%0d exp=1", obs_ill_count); end
    run_instr(enc_i(12'd0, 5'd5, 3'd0, 5'd5), 32'h40);
    tests_run++;
    if (obs_data !== 32'hFFFF_F000) begin tests_failed++; $display("FAIL illegal_no_write got=%h exp=fffff000", obs_data); end
  endtask

  task automatic test_back_to_back();
    run_instr(enc_i(12'h123, 5'd0, 3'd0, 5'd9), 32'h50);
    run_instr(enc_i(12'd1, 5'd9, 3'd0, 5'd10), 32'h54);
    tests_run++;
    if (obs_data !== 32'h124) begin tests_failed++; $display("FAIL back_to_back got=%h exp=00000124", obs_data); end
  endtask

  task automatic test_reset_midflight();
    int waitc;
    waitc = 0;
    run_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd7), 32'h60);
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr = enc_i(12'd9, 5'd0, 3'd0, 5'd7); bus.pc = 32'h64;
    while (bus.instr_ready !== 1'b1 && waitc < 20) begin @(negedge clk); waitc++; end
    @(posedge clk);
    @(negedge clk);          // DECODE
    bus.instr_valid = 1'b0;
    @(negedge clk);          // EXEC
    tests_run++;
    if (bus.ex_en !== 1'b1) begin tests_failed++; $display("FAIL midreset_exec got=%b exp=1", bus.ex_en); end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.retire_valid, bus.instr_ready, bus.ex_en} !== 3'b000) begin
      tests_failed++; $display("FAIL midreset_quiet got=%b exp=000", {bus.retire_valid, bus.instr_ready, bus.ex_en});
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    tests_run++;
    if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_ready got=%b exp=1", bus.instr_ready); end
    for (int i = 0; i < 32; i++) ref_x[i] = '0;
    ref_retired = 0;
`ifdef ISSUE_PERF_CNT_EN
    tests_run++;
    if (bus.retired_count !== 32'd0) begin tests_failed++; $display("FAIL midreset_count got=%0d exp=0", bus.retired_count); end
`endif
    run_instr(enc_i(12'd0, 5'd7, 3'd0, 5'd7), 32'h68);
    tests_run++;
    if (obs_data !== 32'd0) begin tests_failed++; $display("FAIL midreset_x7 got=%h exp=0", obs_data); end
  endtask

  task automatic test_random();
    logic [31:0] ins, p;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    int          sel;
    for (int n = 0; n < 160; n++) begin
      sel = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      f3  = 3'($urandom_range(0, 7));
      p   = $urandom & 32'hFFFF_FFFC;
      if (sel <= 2) begin
        ins = enc_r(($urandom_range(0, 9) == 0) ? 7'($urandom) :
                    ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00), rs2, rs1, f3, rd);
      end else if (sel <= 5) begin
        ins = enc_i(12'($urandom), rs1, f3, rd);
        if (f3 == 3'd1 || f3 == 3'd5)
          ins[31:25] = ($urandom_range(0, 5) == 0) ? 7'($urandom) :
                       ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
      end else if (sel <= 7) begin
        ins = enc_b(13'($urandom) & 13'h1FFE, rs2, rs1, f3);
      end else if (sel == 8) begin
        ins = enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      end else begin
        ins = $urandom;
      end
      run_instr(ins, p);
      tests_run++;
      if (obs_ex_count !== ((exp_kind == 2) ? 0 : 1) || obs_ill_count !== ((exp_kind == 2) ? 1 : 0)) begin
        tests_failed++; $display("FAIL rand_class instr=%h got=ex%0d ill%0d exp_kind=%0d", ins, obs_ex_count, obs_ill_count, exp_kind);
      end
      tests_run++;
      if (obs_ready_cycle !== ((exp_kind == 2) ? 2 : 4)) begin
        tests_failed++; $display("FAIL rand_ready instr=%h got=%0d exp=%0d", ins, obs_ready_cycle, (exp_kind == 2) ? 2 : 4);
      end
      if (exp_kind != 2) begin
        tests_run++;
        if (obs_ret_count !== 1 || obs_ret_cycle !== 3 || obs_rd !== exp_rd || obs_bv !== (exp_kind == 1)) begin
          tests_failed++; $display("FAIL rand_retire instr=%h got=n%0d@%0d x%0d bv%b exp=n1@3 x%0d bv%b",
                                   ins, obs_ret_count, obs_ret_cycle, obs_rd, obs_bv, exp_rd, exp_kind == 1);
        end
      end
      if (exp_kind == 0 && exp_rd != 5'd0) begin
        tests_run++;
        if (obs_data !== exp_val) begin tests_failed++; $display("FAIL rand_data instr=%h got=%h exp=%h", ins, obs_data, exp_val); end
      end
      if (exp_kind == 1) begin
        tests_run++;
        if (obs_tk !== exp_tk || obs_tgt !== exp_tgt) begin
          tests_failed++; $display("FAIL rand_branch instr=%h got=tk%b %h exp=tk%b %h", ins, obs_tk, obs_tgt, exp_tk, exp_tgt);
        end
      end
`ifdef ISSUE_PERF_CNT_EN
      tests_run++;
      if (bus.retired_count !== 32'(ref_retired)) begin
        tests_failed++; $display("FAIL rand_count got=%0d exp=%0d", bus.retired_count, ref_retired);
      end
`endif
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.pc = '0;
    test_reset();
    test_addi_add();
    test_x0();
    test_branch();
    test_lui_auipc();
    test_illegal();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish by 1ms");
    $fatal(1, "watchdog");
  end

endmodule
